pipeline_arbiter: RTL

PIPELINE_ARBITER -- requirements
Module: pipeline_arbiter

---
 rtl/pipeline_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter feeding one registered pipeline input.
// Eligible requesters are scanned starting at rr_ptr. The winner's address
// and ID are captured into the output register whenever that register is
// empty or being consumed.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module pipeline_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SRC_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*`ADDRESS_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*`ID_WIDTH-1:0]    req_id,
    output logic [NUM_REQ-1:0]              req_stall,
    input  logic [NUM_REQ-1:0]              req_mask,
    output logic [`ADDRESS_WIDTH-1:0]       out_address,
    output logic [`ID_WIDTH-1:0]            out_id,
    output logic                            out_valid,
    output logic [SRC_WIDTH-1:0]            out_src,
    input  logic                            in_stall,
    output logic [15:0]                     grant_count
);

    localparam int AW = `ADDRESS_WIDTH;
    localparam int IW = `ID_WIDTH;

    logic [NUM_REQ-1:0]   eligible;
    logic                 any_eligible;
    logic [SRC_WIDTH-1:0] winner;
    logic [SRC_WIDTH-1:0] rr_ptr;
    logic [SRC_WIDTH-1:0] rr_next;
    logic                 load;
    logic [AW-1:0]        sel_address;
    logic [IW-1:0]        sel_id;

    // Output register may take new data when it is empty or being drained.
    assign load     = !out_valid || !in_stall;
    assign eligible = req_valid & req_mask;

    // Round-robin scan: first eligible index starting at rr_ptr, wrapping.
    always_comb begin
        int idx;
        winner       = '0;
        any_eligible = 1'b0;
        idx          = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any_eligible && (|(eligible & (NUM_REQ'(1) << idx)))) begin
                winner       = SRC_WIDTH'(idx);
                any_eligible = 1'b1;
            end else begin
                winner       = winner;
                any_eligible = any_eligible;
            end
        end
    end

    // Pointer moves to the requester after the winner, wrapping at NUM_REQ-1.
    always_comb begin
        if (winner == SRC_WIDTH'(NUM_REQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = winner + SRC_WIDTH'(1);
        end
    end

    // Winner's payload mux, using constant slice positions.
    always_comb begin
        sel_address = '0;
        sel_id      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == SRC_WIDTH'(i)) begin
                sel_address = req_address[i*AW +: AW];
                sel_id      = req_id[i*IW +: IW];
            end else begin
                sel_address = sel_address;
                sel_id      = sel_id;
            end
        end
    end

    // Only the winner sees stall low, and only when the register can load.
    always_comb begin
        req_stall = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (load && any_eligible && (winner == SRC_WIDTH'(i))) begin
                req_stall[i] = 1'b0;
            end else begin
                req_stall[i] = 1'b1;
            end
        end
    end

    // Output register, round-robin pointer and accept counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_address <= '0;
            out_id      <= '0;
            out_src     <= '0;
            rr_ptr      <= '0;
            grant_count <= 16'h0000;
        end else if (load) begin
            if (any_eligible) begin
                out_valid   <= 1'b1;
                out_address <= sel_address;
                out_id      <= sel_id;
                out_src     <= winner;
                rr_ptr      <= rr_next;
                grant_count <= grant_count + 16'h0001;
            end else begin
                out_valid   <= 1'b0;
            end
        end else begin
            out_valid   <= out_valid;
        end
    end

endmodule
